// File: rtl/pipeline_freeze_controller.sv
// Per-stage freeze/flush control from hazard, SRAM-wait and branch inputs; controls are combinational
// from state+inputs (zero latency), with a SRAM wait FSM, sticky watchdog and saturating statistics.
module pipeline_freeze_controller #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hazard_i,
    input  logic             mem_access_i,
    input  logic             sram_ready_i,
    input  logic             branch_taken_i,
    input  logic             cnt_clr_i,
    output logic             freeze_pc_o,
    output logic             freeze_if_id_o,
    output logic             freeze_back_o,
    output logic             flush_if_id_o,
    output logic             flush_id_exe_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] memwait_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] memwait_q, memwait_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             mem_block;
    logic             stall_ev, memwait_ev, flush_ev;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic clr, input logic ev);
        if (clr)
            return '0;
        else if (ev && !(&cur))
            return cur + CNT_W'(1);
        else
            return cur;
    endfunction

    assign mem_block = mem_access_i & ~sram_ready_i;

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        timeout_d      = timeout_q;
        freeze_pc_o    = 1'b0;
        freeze_if_id_o = 1'b0;
        freeze_back_o  = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_exe_o = 1'b0;
        stall_ev       = 1'b0;
        memwait_ev     = 1'b0;
        flush_ev       = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_block) begin
                    freeze_pc_o    = 1'b1;
                    freeze_if_id_o = 1'b1;
                    freeze_back_o  = 1'b1;
                    memwait_ev     = 1'b1;
                    state_d        = MEM_WAIT;
                    wait_d         = WW'(1);
                end else if (branch_taken_i) begin
                    // the branch squashes the hazarding instruction, so no stall is needed
                    flush_if_id_o  = 1'b1;
                    flush_id_exe_o = 1'b1;
                    flush_ev       = 1'b1;
                end else if (hazard_i) begin
                    freeze_pc_o    = 1'b1;
                    freeze_if_id_o = 1'b1;
                    flush_id_exe_o = 1'b1;
                    stall_ev       = 1'b1;
                end
            end
            MEM_WAIT: begin
                freeze_pc_o    = 1'b1;
                freeze_if_id_o = 1'b1;
                freeze_back_o  = 1'b1;
                memwait_ev     = 1'b1;
                if (sram_ready_i) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WW'(1);
                    if (wait_d == WW'(MAX_WAIT)) begin
                        state_d   = ERROR;
                        timeout_d = 1'b1;
                    end
                end
            end
            ERROR: begin
                freeze_pc_o    = 1'b1;
                freeze_if_id_o = 1'b1;
                freeze_back_o  = 1'b1;
                timeout_d      = 1'b1;
            end
            default: state_d = RUN;
        endcase

        // the pipeline must see no control activity while reset is asserted
        if (rst_i) begin
            freeze_pc_o    = 1'b0;
            freeze_if_id_o = 1'b0;
            freeze_back_o  = 1'b0;
            flush_if_id_o  = 1'b0;
            flush_id_exe_o = 1'b0;
        end

        stall_d   = cnt_next(stall_q, cnt_clr_i, stall_ev);
        memwait_d = cnt_next(memwait_q, cnt_clr_i, memwait_ev);
        flush_d   = cnt_next(flush_q, cnt_clr_i, flush_ev);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            memwait_q <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            memwait_q <= memwait_d;
            flush_q   <= flush_d;
        end
    end

    assign mem_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_q;
    assign memwait_cnt_o = memwait_q;
    assign flush_cnt_o   = flush_q;

endmodule
